// File: rtl/lisa_autobaud_pkg.sv
// lisa_autobaud_pkg
//   Shared definitions for the auto-baud detector: the search/lock state
//   encoding and the fixed protocol constants of the 0x55 sync character.
package lisa_autobaud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_START,
        MEASURE,
        CALC,
        LOCKED
    } state_t;

    // Falling edges in 0x55: start bit, then the falls into d1, d3, d5 and d7.
    localparam int unsigned SYNC_EDGES = 5;
    // Consecutive high clocks that qualify the line as idle before a search.
    localparam int unsigned HIGH_QUAL  = 16;

endpackage

// File: rtl/lisa_sync_edge.sv
// lisa_sync_edge
//   Two-flop synchroniser for an asynchronous serial line, plus a one-cycle
//   falling-edge pulse taken from the synchronised value.
//   Ports:
//     clk   in   system clock
//     rst_n in   asynchronous active-low reset (line resets to idle-high)
//     din   in   raw asynchronous input
//     dout  out  synchronised line level
//     fe    out  1 for one cycle when dout goes 1 -> 0
module lisa_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fe
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
        end
    end

    assign dout = sync[1];
    assign fe   = prev & ~sync[1];

endmodule

// File: rtl/lisa_autobaud.sv
// lisa_autobaud
//   Auto-baud detector. Waits for an idle line, then times the sync
//   character 0x55 from the start-bit fall to the d7 fall (8 bit-times),
//   checks that every two-bit interval is consistent, and converts the span
//   into a divider for the oversampling baud generator.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     en       in   level enable; 0 forces IDLE and clears the lock
//     rearm    in   one-cycle pulse; drop the lock and search again
//     rxd      in   raw asynchronous serial input
//     baud_set out  1 = baud_div valid and locked
//     baud_div out  divider value for the baud generator
//     err      out  one-cycle pulse on a rejected sync attempt
//   Build option:
//     LISA_AUTOBAUD_BREAK_EN  when defined, a low time of 2x the measured
//                             8-bit span while locked drops the lock.
module lisa_autobaud
    import lisa_autobaud_pkg::*;
#(
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned OVERSAMPLE_LOG2 = 3,
    parameter int unsigned TOL_SHIFT       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rearm,
    input  logic       rxd,
    output logic       baud_set,
    output logic [6:0] baud_div,
    output logic       err
);

    // q = (span + half-divisor) / (8 bit-times * oversample), rounded.
    localparam int unsigned   Q_SHIFT = OVERSAMPLE_LOG2 + 3;
    localparam logic [CNT_W:0] Q_RND  = (CNT_W + 1)'(1) << (OVERSAMPLE_LOG2 + 2);
    localparam logic [CNT_W:0] Q_MIN  = (CNT_W + 1)'(2);
    localparam logic [CNT_W:0] Q_MAX  = (CNT_W + 1)'(128);

    logic rxs;
    logic fe;

    lisa_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rxd),
        .dout  (rxs),
        .fe    (fe)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] ref_int;
    logic [2:0]       edge_n;
    logic [4:0]       hcnt;

    // Interval length including the edge cycle itself.
    logic [CNT_W:0] cur_int;
    logic [CNT_W:0] ref_w;
    logic [CNT_W:0] diff;
    logic [CNT_W:0] tol;
    logic           in_tol;
    logic [CNT_W:0] q;
    logic [6:0]     div_nxt;
    logic           q_ok;

    always_comb begin
        cur_int = {1'b0, icnt} + 1'b1;
        ref_w   = {1'b0, ref_int};
        diff    = (cur_int >= ref_w) ? (cur_int - ref_w) : (ref_w - cur_int);
        tol     = ref_w >> TOL_SHIFT;
        in_tol  = (diff <= tol);
        q       = ({1'b0, cnt} + Q_RND) >> Q_SHIFT;
        q_ok    = (q >= Q_MIN) && (q <= Q_MAX);
        div_nxt = q[6:0] - 7'd1;
    end

`ifdef LISA_AUTOBAUD_BREAK_EN
    logic [CNT_W-1:0] cnt_locked;
    logic [CNT_W:0]   lcnt;
    logic [CNT_W:0]   lcnt_nxt;
    logic [CNT_W:0]   brk_len;

    always_comb begin
        lcnt_nxt = lcnt + 1'b1;
        brk_len  = {cnt_locked, 1'b0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            icnt     <= '0;
            ref_int  <= '0;
            edge_n   <= '0;
            hcnt     <= '0;
            baud_set <= 1'b0;
            baud_div <= '0;
            err      <= 1'b0;
`ifdef LISA_AUTOBAUD_BREAK_EN
            cnt_locked <= '0;
            lcnt       <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                baud_set <= 1'b0;
            end else if (rearm) begin
                state    <= WAIT_HIGH;
                hcnt     <= '0;
                baud_set <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hcnt  <= '0;
                        state <= WAIT_HIGH;
                    end

                    WAIT_HIGH: begin
                        if (!rxs) begin
                            hcnt <= '0;
                        end else if (hcnt == 5'(HIGH_QUAL - 1)) begin
                            state <= WAIT_START;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end

                    WAIT_START: begin
                        if (fe) begin
                            cnt    <= '0;
                            icnt   <= '0;
                            edge_n <= 3'd1;
                            state  <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        if (cnt == '1 || icnt == '1) begin
                            // Too slow to be measured.
                            err   <= 1'b1;
                            hcnt  <= '0;
                            state <= WAIT_HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (fe) begin
                                if (edge_n != 3'd1 && !in_tol) begin
                                    err   <= 1'b1;
                                    hcnt  <= '0;
                                    state <= WAIT_HIGH;
                                end else begin
                                    // First full interval becomes the reference.
                                    if (edge_n == 3'd1) begin
                                        ref_int <= cur_int[CNT_W-1:0];
                                    end
                                    icnt   <= '0;
                                    edge_n <= edge_n + 1'b1;
                                    if (edge_n == 3'(SYNC_EDGES - 1)) begin
                                        state <= CALC;
                                    end
                                end
                            end else begin
                                icnt <= icnt + 1'b1;
                            end
                        end
                    end

                    CALC: begin
                        if (q_ok) begin
                            baud_div <= div_nxt;
                            baud_set <= 1'b1;
                            state    <= LOCKED;
`ifdef LISA_AUTOBAUD_BREAK_EN
                            cnt_locked <= cnt;
                            lcnt       <= '0;
`endif
                        end else begin
                            err   <= 1'b1;
                            hcnt  <= '0;
                            state <= WAIT_HIGH;
                        end
                    end

                    LOCKED: begin
`ifdef LISA_AUTOBAUD_BREAK_EN
                        // A low run of ~16 bit-times is a host break request.
                        if (rxs) begin
                            lcnt <= '0;
                        end else if (lcnt_nxt >= brk_len) begin
                            lcnt     <= '0;
                            baud_set <= 1'b0;
                            hcnt     <= '0;
                            state    <= WAIT_HIGH;
                        end else begin
                            lcnt <= lcnt_nxt;
                        end
`else
                        state <= LOCKED;
`endif
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lisa_autobaud.sv
module tb_lisa_autobaud;
    import lisa_autobaud_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       rearm = 1'b0;
    logic       rxd   = 1'b1;
    logic       baud_set;
    logic [6:0] baud_div;
    logic       err;

    lisa_autobaud #(
        .CNT_W           (16),
        .OVERSAMPLE_LOG2 (3),
        .TOL_SHIFT       (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rearm    (rearm),
        .rxd      (rxd),
        .baud_set (baud_set),
        .baud_div (baud_div),
        .err      (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned period;
        logic [7:0]  ch;
        bit          exp_lock;
        logic [6:0]  exp_div;
    } vec_t;

    typedef struct {
        bit         lock;
        logic [6:0] div;
    } exp_t;

    vec_t tbl[8];
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame: start bit, d0..d7 LSB first, stop bit; each held 'p' clocks.
    task automatic send_char(input int unsigned p, input logic [7:0] ch, output int unsigned d7_cyc);
        logic [9:0] frame;
        frame  = {1'b1, ch, 1'b0};
        d7_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = frame[i];
            if (i == 8) d7_cyc = cyc;
            repeat (p - 1) @(negedge clk);
        end
    endtask

    task automatic watch(input int unsigned limit, output bit got_lock, output bit got_err,
                         output int unsigned ev_cyc);
        got_lock = 1'b0;
        got_err  = 1'b0;
        ev_cyc   = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (err) begin
                got_err = 1'b1;
                ev_cyc  = cyc;
                break;
            end
            if (baud_set) begin
                got_lock = 1'b1;
                ev_cyc   = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input int unsigned p, input logic [7:0] ch,
                           input bit exp_lock, input logic [6:0] exp_div);
        exp_t        e;
        bit          got_lock;
        bit          got_err;
        int unsigned ev_cyc;
        int unsigned d7_cyc;
        e.lock = exp_lock;
        e.div  = exp_div;
        sbq.push_back(e);
        fork
            send_char(p, ch, d7_cyc);
            watch(12 * p + 200, got_lock, got_err, ev_cyc);
        join
        if (sbq.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check({name, "_lock"}, 32'(got_lock), 32'(e.lock));
            check({name, "_err"}, 32'(got_err), 32'(!e.lock));
            if (e.lock) begin
                check({name, "_div"}, 32'(baud_div), 32'(e.div));
                check({name, "_lat_le5"}, 32'((ev_cyc >= d7_cyc) && (ev_cyc - d7_cyc <= 5)), 32'd1);
            end else begin
                check({name, "_noset"}, 32'(baud_set), 32'd0);
            end
        end
    endtask

    task automatic do_rearm(input string name);
        @(negedge clk);
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        check(name, 32'(baud_set), 32'd0);
    endtask

    initial begin
        bit prev_lock;

        tbl[0] = '{656,  8'h55, 1'b1, 7'd81};
        tbl[1] = '{660,  8'h55, 1'b1, 7'd82};
        tbl[2] = '{652,  8'h55, 1'b1, 7'd81};
        tbl[3] = '{656,  8'h0D, 1'b0, 7'd0};
        tbl[4] = '{656,  8'h55, 1'b1, 7'd81};
        tbl[5] = '{8,    8'h55, 1'b0, 7'd0};
        tbl[6] = '{1040, 8'h55, 1'b0, 7'd0};
        tbl[7] = '{1024, 8'h55, 1'b1, 7'd127};

        repeat (3) @(negedge clk);
        check("rst_baud_set", 32'(baud_set), 32'd0);
        check("rst_baud_div", 32'(baud_div), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        en    = 1'b1;

        prev_lock = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (prev_lock) do_rearm($sformatf("rearm_clear%0d", i));
            repeat (100) @(negedge clk);
            run_vec($sformatf("vec%0d", i), tbl[i].period, tbl[i].ch, tbl[i].exp_lock, tbl[i].exp_div);
            prev_lock = tbl[i].exp_lock;
        end

        // rearm together with en=0: en wins, state goes to IDLE, divider held.
        @(negedge clk);
        rearm = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        rearm = 1'b0;
        check("prio_baud_set", 32'(baud_set), 32'd0);
        check("prio_state", 32'(dut.state), 32'(IDLE));
        check("prio_div_held", 32'(baud_div), 32'd127);
        repeat (20) @(negedge clk);
        check("prio_stays_idle", 32'(dut.state), 32'(IDLE));

        // Reset in the middle of a measurement.
        en = 1'b1;
        repeat (100) @(negedge clk);
        rxd = 1'b0;
        repeat (656) @(negedge clk);
        rxd = 1'b1;
        repeat (656) @(negedge clk);
        rxd = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_state_measure", 32'(dut.state), 32'(MEASURE));
        rst_n = 1'b0;
        #1;
        check("mid_rst_baud_set", 32'(baud_set), 32'd0);
        check("mid_rst_baud_div", 32'(baud_div), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Lock, then hold the line low for longer than 16 bit-times.
        repeat (100) @(negedge clk);
        run_vec("brk_lock", 656, 8'h55, 1'b1, 7'd81);
        repeat (200) @(negedge clk);
        rxd = 1'b0;
        repeat (10500) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
`ifdef LISA_AUTOBAUD_BREAK_EN
        check("brk_baud_set", 32'(baud_set), 32'd0);
`else
        check("brk_baud_set", 32'(baud_set), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
